// File: rtl/reg_bus_arbiter.sv
// Two-master round-robin arbiter for the internal register bus with a fixed read latency.
// Define REG_BUS_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (port 0 wins).
module reg_bus_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic              i_wr0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [DATA_W-1:0] i_wdata0,
  output logic              o_gnt0,
  output logic              o_done0,
  output logic [DATA_W-1:0] o_rdata0,
  input  logic              i_req1,
  input  logic              i_wr1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt1,
  output logic              o_done1,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [ADDR_W-1:0] o_addr_bus,
  output logic [DATA_W-1:0] o_data_write_bus,
  output logic              o_wr_enable_bus,
  input  logic [DATA_W-1:0] i_data_read_bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

  localparam logic [3:0] LatCnt = 4'(READ_LAT);

  state_e     state;
  logic       owner;
  logic [3:0] cnt;
  logic       sel_valid;
  logic       sel;

`ifdef REG_BUS_ARB_FIXED_PRIO_EN
  always_comb begin
    sel_valid = i_req0 | i_req1;
    sel       = ~i_req0;
  end
`else
  logic last;

  // On a tie the port that did not finish most recently wins.
  always_comb begin
    sel_valid = i_req0 | i_req1;
    sel       = (i_req0 & i_req1) ? ~last : i_req1;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= StIdle;
      owner            <= 1'b0;
      cnt              <= 4'd0;
      o_gnt0           <= 1'b0;
      o_gnt1           <= 1'b0;
      o_done0          <= 1'b0;
      o_done1          <= 1'b0;
      o_rdata0         <= '0;
      o_rdata1         <= '0;
      o_addr_bus       <= '0;
      o_data_write_bus <= '0;
      o_wr_enable_bus  <= 1'b0;
`ifndef REG_BUS_ARB_FIXED_PRIO_EN
      last             <= 1'b1;
`endif
    end else begin
      o_done0 <= 1'b0;
      o_done1 <= 1'b0;
      unique case (state)
        StIdle: begin
          if (sel_valid) begin
            owner            <= sel;
            o_addr_bus       <= sel ? i_addr1 : i_addr0;
            o_data_write_bus <= sel ? i_wdata1 : i_wdata0;
            o_wr_enable_bus  <= sel ? i_wr1 : i_wr0;
            o_gnt0           <= ~sel;
            o_gnt1           <= sel;
            state            <= StAccess;
          end
        end
        StAccess: begin
          // Strobe lasts exactly the ACCESS cycle; address and data stay put until the next grant.
          o_wr_enable_bus <= 1'b0;
          cnt             <= 4'd1;
          state           <= StWait;
        end
        StWait: begin
          if (cnt == LatCnt) begin
            if (owner) o_rdata1 <= i_data_read_bus;
            else       o_rdata0 <= i_data_read_bus;
            o_done0 <= ~owner;
            o_done1 <= owner;
            state   <= StDone;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        StDone: begin
          o_gnt0 <= 1'b0;
          o_gnt1 <= 1'b0;
`ifndef REG_BUS_ARB_FIXED_PRIO_EN
          last   <= owner;
`endif
          state  <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
- Shares the internal register bus between two masters: port 0 is the SPI-side register controller, port 1 is the local configuration/sequencer master.
- Masters cannot drive the bus directly. They issue single read or write transactions to this block through a req/done handshake.
- The block grants one master at a time by round-robin and drives the bus.
- It waits the fixed read latency, returns read data and signals completion.

Parameters:
- ADDR_W, 8, register address width
- DATA_W, 8, register data width
- READ_LAT, 1, cycles from address valid to i_data_read_bus valid; legal range 1..15

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_req0  in  1  port 0 transaction request; level, held until o_done0
- i_wr0  in  1  port 0 direction: 1 = write, 0 = read; stable while i_req0 high
- i_addr0  in  ADDR_W  port 0 address
- i_wdata0  in  DATA_W  port 0 write data
- o_gnt0  out  1  port 0 owns the bus
- o_done0  out  1  one-cycle completion pulse for port 0
- o_rdata0  out  DATA_W  port 0 read data, valid when o_done0 = 1
- i_req1, i_wr1, i_addr1, i_wdata1, o_gnt1, o_done1, o_rdata1: same as port 0, for port 1
- o_addr_bus  out  ADDR_W  register bus address
- o_data_write_bus  out  DATA_W  register bus write data
- o_wr_enable_bus  out  1  register bus write strobe
- i_data_read_bus  in  DATA_W  register bus read data

Behaviour:
- All outputs are registered.
- Reset values:
  - all outputs 0
  - state IDLE
  - round-robin pointer last = 1, so port 0 wins the first contest
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - Only one req high: select that port.
  - Both high: select the port != last.
  - Selection latches owner, addr, wdata and wr; next state is ACCESS.
  - No req: stay in IDLE.
- ACCESS (exactly 1 cycle):
  - o_addr_bus and o_data_write_bus hold the latched values.
  - o_wr_enable_bus = latched wr, for this cycle only.
  - o_gnt<owner> = 1.
  - Next state is WAIT with counter = 1.
- WAIT:
  - Counter increments each cycle.
  - When counter == READ_LAT, capture i_data_read_bus into o_rdata<owner>; next state is DONE.
  - o_addr_bus stays stable the whole time; o_wr_enable_bus = 0.
- DONE (1 cycle):
  - o_done<owner> = 1; o_gnt<owner> stays 1.
  - last <= owner; next state is IDLE.
- Latency: a request seen in IDLE at cycle t gives:
  - ACCESS at t+1
  - o_done at t+READ_LAT+2
- Read/write timing is identical. For writes, o_rdata still captures the bus (don't-care to the master).
- Handshake rule: the master must deassert req in the cycle o_done is high, so IDLE never re-samples a finished request. A req still high in that cycle is treated as a new transaction.
- Back-to-back requests from both ports alternate 0,1,0,1.
- Minimum spacing between ACCESS cycles is READ_LAT+3.
- req dropped mid-transaction: the transaction still completes and o_done still pulses. The bus is never left half-driven.
- Inputs not sampled in IDLE are ignored (addr/wdata/wr changes mid-transaction have no effect).
- o_rdata<n> holds its value until that port's next completed transaction.
- The non-owner's gnt/done are 0 at all times.
- i_rst mid-transaction: next cycle all outputs are 0, state is IDLE, last = 1. An in-flight write whose ACCESS had not occurred is never strobed.

Optional Feature:
- Macro: REG_BUS_ARB_FIXED_PRIO_EN.
- Defined:
  - Round-robin is replaced by fixed priority, port 0 (SPI) always winning a simultaneous request.
  - The last pointer is not implemented.
- Undefined: round-robin as described above.
- Timing and handshake are identical in both builds.

Test Plan:
- Port 0 write only, i_addr0=8'h05, i_wdata0=8'hA5, READ_LAT=1, req at cycle 0 ->
  - cycle 1: o_addr_bus=8'h05, o_data_write_bus=8'hA5, o_wr_enable_bus=1 for exactly one cycle
  - cycle 3: o_done0=1
- Port 1 read, i_addr1=8'h10, bus returns 8'h3C one cycle after address, READ_LAT=1 -> o_done1 pulses with o_rdata1=8'h3C; o_wr_enable_bus stays 0 throughout.
- Both ports request continuously from reset (each deasserting on done and re-asserting next cycle) -> grants alternate 0,1,0,1. With REG_BUS_ARB_FIXED_PRIO_EN: port 0 wins every contested IDLE.
- READ_LAT=3, port 0 read of 8'h02, i_data_read_bus changes each cycle -> o_rdata0 equals the bus value 3 cycles after ACCESS; o_done0 at cycle 5.
- i_req0 dropped in the WAIT cycle of a read -> o_done0 still pulses; the arbiter returns to IDLE and serves a pending i_req1 next.
- i_rst asserted during WAIT of a port 1 write -> the following cycle has all outputs 0. The next port 0 request is granted first (last=1).
